// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with terminal-count pulse
// Optional periodic reload build: define COUNTDOWN_TIMER_RELOAD_EN.
module countdown_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t state;

`ifdef COUNTDOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            reload_q <= ZERO;
        end else if (load) begin
            reload_q <= cnt_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt_out <= ZERO;
            busy    <= 1'b0;
            tc      <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                cnt_out <= cnt_in;
                if (cnt_in != ZERO) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == RUN && enab) begin
                if (cnt_out > ONE) begin
                    cnt_out <= cnt_out - ONE;
                end else if (cnt_out == ONE) begin
                    tc <= 1'b1;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
                    cnt_out <= reload_q;
`else
                    cnt_out <= ZERO;
                    state   <= IDLE;
                    busy    <= 1'b0;
`endif
                end else begin
                    // A zero count in RUN is unreachable; park safely without a pulse.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule
